sync_updown_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 58 +++++
 rtl/sync_updown_counter_if.sv | 41 ++++
 rtl/sync_updown_counter_prescaler.sv | 39 +++
 rtl/sync_updown_counter.sv | 118 +++++++++++
 tb/tb_sync_updown_counter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Purpose: shared types, width helpers and parameter-legality checks for counter/timer blocks.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
//
// Contents:
//   count_dir_e       direction encoding shared with the dir port (DIR_DOWN=0, DIR_UP=1)
//   clog2/cnt_width   width helpers; cnt_width never returns less than one bit
//   *_ok functions    elaboration-time legality checks reused by other timer blocks
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    localparam int CNT_MIN_WIDTH    = 1;
    localparam int CNT_MAX_WIDTH    = 32;
    localparam int CNT_MIN_MODULUS  = 2;
    localparam int CNT_MIN_PRESCALE = 1;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int clog2(input longint unsigned value);
        int              r;
        longint unsigned v;
        r = 0;
        v = value;
        if (v > 0) begin
            v = v - 1;
        end
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Register width needed to hold 0..value-1, never less than one bit.
    function automatic int cnt_width(input longint unsigned value);
        int w;
        w = clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= CNT_MIN_WIDTH) && (width <= CNT_MAX_WIDTH);
    endfunction

    // MODULUS may be as large as 2^WIDTH, which needs 33 bits when WIDTH=32.
    function automatic bit modulus_ok(input int width, input longint modulus);
        return (modulus >= longint'(CNT_MIN_MODULUS)) &&
               (modulus <= (longint'(1) << width));
    endfunction

    function automatic bit prescale_ok(input int prescale);
        return prescale >= CNT_MIN_PRESCALE;
    endfunction

endpackage

// File: rtl/sync_updown_counter_if.sv
// Purpose: control/status bundle between a counter and the block that drives it.
// Latency: n/a (wires only).
// Backpressure: none; the counter has no ready, en simply stalls it.
//
// Signals:
//   en        count enable (gates prescaler and counter)
//   dir       1 = up, 0 = down (see counter_pkg::count_dir_e)
//   load      synchronous parallel-load strobe
//   load_val  value written on load, clamped to the count range
//   q         registered count value
//   tc        registered one-cycle terminal-count pulse
// Modports: master drives the controls and observes q/tc; slave is the counter.
interface sync_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output en,
        output dir,
        output load,
        output load_val,
        input  q,
        input  tc
    );

    modport slave (
        input  en,
        input  dir,
        input  load,
        input  load_val,
        output q,
        output tc
    );

endinterface

// File: rtl/sync_updown_counter_prescaler.sv
// Purpose: divides enabled cycles by PRESCALE, producing a one-cycle step tick.
// Latency: tick is combinational from en and the registered phase count.
// Backpressure: en low freezes the phase count; clr restarts the period.
//
// Ports:
//   clk    sole clock
//   reset  synchronous active-high reset, clears the phase count
//   en     advance the phase count this cycle
//   clr    restart the period (driven by the counter's load strobe)
//   tick   high on the enabled cycle that completes a period
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = cnt_width(longint'(PRESCALE));
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    // With PRESCALE=1 LAST is 0, so pcnt sits at 0 and tick degenerates to en.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
        end
    end

    assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/sync_updown_counter.sv
// Purpose: synchronous modulo-MODULUS up/down counter with load, prescaled enable and tc pulse.
// Latency: one cycle from sampled inputs to q and tc.
// Backpressure: none; en low holds q and the prescaler phase, tc drops.
//
// Ports:
//   clk    sole clock, all state on posedge
//   reset  synchronous active-high reset (beats load and en)
//   bus    sync_updown_counter_if.slave: en, dir, load, load_val in; q, tc out
// Build option: define COUNTER_SATURATE_EN to hold at the bounds instead of wrapping;
// tc then marks the step that first reaches a bound.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    sync_updown_counter_if.slave  bus
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("sync_updown_counter: WIDTH %0d outside 1..32", WIDTH);
    end
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("sync_updown_counter: MODULUS %0d outside 2..2^WIDTH", MODULUS);
    end
    if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
        $error("sync_updown_counter: PRESCALE %0d must be >= 1", PRESCALE);
    end

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
    // 33 bits so the load clamp compare also works for WIDTH=32, MODULUS=2^32.
    localparam logic [32:0]      MOD_EXT = 33'(MODULUS);

    logic             tick;
    count_dir_e       step_dir;
    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic [WIDTH-1:0] load_clamped;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.load),
        .tick  (tick)
    );

    assign step_dir     = count_dir_e'(bus.dir);
    assign q_inc        = q_r + WIDTH'(1);
    assign q_dec        = q_r - WIDTH'(1);
    assign load_clamped = (33'(bus.load_val) < MOD_EXT) ? bus.load_val : MAX_Q;

    // Load beats a step; dir is only looked at on a tick.
    // Codes above MAX_Q are unreachable, but are steered back into range
    // rather than left to count through unused codes.
    always_comb begin
        q_nxt  = q_r;
        tc_nxt = 1'b0;
        if (bus.load) begin
            q_nxt = load_clamped;
        end else if (tick) begin
            if (step_dir == DIR_UP) begin
                if (q_r >= MAX_Q) begin
`ifdef COUNTER_SATURATE_EN
                    q_nxt  = MAX_Q;
`else
                    q_nxt  = '0;
                    tc_nxt = 1'b1;
`endif
                end else begin
                    q_nxt  = q_inc;
`ifdef COUNTER_SATURATE_EN
                    tc_nxt = (q_inc == MAX_Q);
`endif
                end
            end else begin
                if (q_r == '0) begin
`ifdef COUNTER_SATURATE_EN
                    q_nxt  = '0;
`else
                    q_nxt  = MAX_Q;
                    tc_nxt = 1'b1;
`endif
                end else if (q_r > MAX_Q) begin
                    q_nxt  = MAX_Q;
                end else begin
                    q_nxt  = q_dec;
`ifdef COUNTER_SATURATE_EN
                    tc_nxt = (q_dec == '0);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r  <= '0;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_nxt;
            tc_r <= tc_nxt;
        end
    end

    assign bus.q  = q_r;
    assign bus.tc = tc_r;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Purpose: directed check of three counter builds: defaults (M16,P1), MODULUS=10, PRESCALE=3.
// Inputs change 1ns after posedge; outputs are sampled there too, reflecting that edge.
module tb_sync_updown_counter;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    sync_updown_counter_if #(.WIDTH(4)) if_a ();
    sync_updown_counter_if #(.WIDTH(4)) if_b ();
    sync_updown_counter_if #(.WIDTH(4)) if_c ();

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_a (
        .clk (clk), .reset (reset), .bus (if_a));
    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_b (
        .clk (clk), .reset (reset), .bus (if_b));
    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_c (
        .clk (clk), .reset (reset), .bus (if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        {if_a.en, if_a.dir, if_a.load} = 3'b000; if_a.load_val = '0;
        {if_b.en, if_b.dir, if_b.load} = 3'b000; if_b.load_val = '0;
        {if_c.en, if_c.dir, if_c.load} = 3'b000; if_c.load_val = '0;
        step();
        // reset beats load and en
        if_a.en = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd7;
        step();
        chk_eq("rst_q_a", if_a.q, 0);
        chk_eq("rst_tc_a", if_a.tc, 0);
        chk_eq("rst_q_b", if_b.q, 0);
        chk_eq("rst_q_c", if_c.q, 0);

        // up count with wrap, defaults
        reset = 1'b0;
        if_a.load = 1'b0; if_a.en = 1'b1; if_a.dir = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk_eq($sformatf("up_q%0d", k), if_a.q, k % 16);
            chk_eq($sformatf("up_tc%0d", k), if_a.tc, (k % 16 == 0) ? 1 : 0);
        end
        reset = 1'b1;
        step();
        chk_eq("midrst_q", if_a.q, 0);
        chk_eq("midrst_tc", if_a.tc, 0);
        reset = 1'b0;

        // reset landing on what would be a wrap edge emits no tc
        if_a.load = 1'b1; if_a.load_val = 4'd15;
        step();
        chk_eq("ld15_q", if_a.q, 15);
        if_a.load = 1'b0;
        reset = 1'b1;
        step();
        chk_eq("wraprst_q", if_a.q, 0);
        chk_eq("wraprst_tc", if_a.tc, 0);
        reset = 1'b0;
        if_a.en = 1'b0;

        // down wrap, MODULUS=10
        if_b.en = 1'b1; if_b.dir = 1'b0; if_b.load = 1'b1; if_b.load_val = 4'd2;
        step();
        chk_eq("dn_ld_q", if_b.q, 2);
        chk_eq("dn_ld_tc", if_b.tc, 0);
        if_b.load = 1'b0;
        step(); chk_eq("dn_q1", if_b.q, 1); chk_eq("dn_tc1", if_b.tc, 0);
        step(); chk_eq("dn_q0", if_b.q, 0); chk_eq("dn_tc0", if_b.tc, 0);
        step(); chk_eq("dn_q9", if_b.q, 9); chk_eq("dn_tc9", if_b.tc, 1);
        step(); chk_eq("dn_q8", if_b.q, 8); chk_eq("dn_tc8", if_b.tc, 0);

        // load priority and clamp, MODULUS=10
        if_b.dir = 1'b1; if_b.load = 1'b1; if_b.load_val = 4'd5;
        step(); chk_eq("ld5_q", if_b.q, 5);
        if_b.load_val = 4'd13;
        step(); chk_eq("ld13_q", if_b.q, 9);
        // q=9, dir up, en: would wrap, but load wins and tc stays low
        if_b.load_val = 4'd3;
        step(); chk_eq("ldwrap_q", if_b.q, 3); chk_eq("ldwrap_tc", if_b.tc, 0);
        if_b.load_val = 4'd10;
        step(); chk_eq("ld10_q", if_b.q, 9);
        if_b.load = 1'b0;
        step(); chk_eq("m10_wrap_q", if_b.q, 0); chk_eq("m10_wrap_tc", if_b.tc, 1);
        if_b.en = 1'b0;
        step(); chk_eq("m10_hold_q", if_b.q, 0); chk_eq("m10_hold_tc", if_b.tc, 0);

        // prescale by 3
        if_c.en = 1'b1; if_c.dir = 1'b1;
        step(); chk_eq("ps_q1", if_c.q, 0);
        step(); chk_eq("ps_q2", if_c.q, 0);
        step(); chk_eq("ps_q3", if_c.q, 1);
        step(); chk_eq("ps_q4", if_c.q, 1);
        step(); chk_eq("ps_q5", if_c.q, 1);
        step(); chk_eq("ps_q6", if_c.q, 2);
        step(); chk_eq("ps_q7", if_c.q, 2);
        if_c.en = 1'b0;
        step(); chk_eq("ps_off1", if_c.q, 2); chk_eq("ps_off1_tc", if_c.tc, 0);
        step(); chk_eq("ps_off2", if_c.q, 2);
        if_c.en = 1'b1;
        step(); chk_eq("ps_str1", if_c.q, 2);
        step(); chk_eq("ps_str2", if_c.q, 3);

        // load restarts the prescale period
        step();  // pcnt now 1
        if_c.load = 1'b1; if_c.load_val = 4'd4;
        step(); chk_eq("ps_ld_q", if_c.q, 4);
        if_c.load = 1'b0;
        step(); chk_eq("ps_ld1", if_c.q, 4);
        step(); chk_eq("ps_ld2", if_c.q, 4);
        step(); chk_eq("ps_ld3", if_c.q, 5);

        // dir flips to down one cycle before the tick at q=15
        if_c.load = 1'b1; if_c.load_val = 4'd15;
        step(); chk_eq("bd_ld", if_c.q, 15);
        if_c.load = 1'b0;
        step(); chk_eq("bd_p1", if_c.q, 15);
        if_c.dir = 1'b0;
        step(); chk_eq("bd_p2", if_c.q, 15);
        step(); chk_eq("bd_q", if_c.q, 14); chk_eq("bd_tc", if_c.tc, 0);

        // reset mid-prescale clears the phase as well
        if_c.dir = 1'b1;
        step();  // pcnt 1
        reset = 1'b1;
        step(); chk_eq("psrst_q", if_c.q, 0); chk_eq("psrst_tc", if_c.tc, 0);
        reset = 1'b0;
        step(); chk_eq("psrst1", if_c.q, 0);
        step(); chk_eq("psrst2", if_c.q, 0);
        step(); chk_eq("psrst3", if_c.q, 1);
        if_c.en = 1'b0;

        // upper bound: saturate build holds, wrap build rolls over
        if_a.en = 1'b1; if_a.dir = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd13;
        step(); chk_eq("sat_ld", if_a.q, 13);
        if_a.load = 1'b0;
        step(); chk_eq("sat_q14", if_a.q, 14); chk_eq("sat_tc14", if_a.tc, 0);
        step(); chk_eq("sat_q15", if_a.q, 15); chk_eq("sat_tc15", if_a.tc, SAT ? 1 : 0);
        step(); chk_eq("sat_q3", if_a.q, SAT ? 15 : 0); chk_eq("sat_tc3", if_a.tc, SAT ? 0 : 1);
        step(); chk_eq("sat_q4", if_a.q, SAT ? 15 : 1); chk_eq("sat_tc4", if_a.tc, 0);
        if_a.dir = 1'b0;
        step(); chk_eq("sat_rev", if_a.q, SAT ? 14 : 0);

        // lower bound
        if_a.load = 1'b1; if_a.load_val = 4'd2;
        step();
        if_a.load = 1'b0;
        step(); chk_eq("lo_q1", if_a.q, 1); chk_eq("lo_tc1", if_a.tc, 0);
        step(); chk_eq("lo_q0", if_a.q, 0); chk_eq("lo_tc0", if_a.tc, SAT ? 1 : 0);
        step(); chk_eq("lo_q2", if_a.q, SAT ? 0 : 15); chk_eq("lo_tc2", if_a.tc, SAT ? 0 : 1);
        if_a.dir = 1'b1;
        step(); chk_eq("lo_rev", if_a.q, SAT ? 1 : 0);
        if_a.en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
